deserializer_out: RTL and testbench

- Receive-side counterpart of the framed transmit path. Consumes the 1-bit/clock serial stream the transmit serializer produces.
- The stream is continuous 9-bit words {k, byte[7:0]}, LSB first. Idle is K-comma words (9'h13C). A frame is COMMA, D0, D1, D2, then trailer {0, 8'hFC}.
- The block finds word alignment on the comma, confirms lock, and parses frames. It emits the 24-bit payload with a 1-cycle valid pulse, or an error pulse on a malformed frame.
- It sits at the receive end of the serial link and feeds the downstream register/consumer logic.

---
 rtl/serdes_pkg.sv | 21 ++
 rtl/deserializer_out_if.sv | 13 +
 rtl/rx_word_align.sv | 38 +++
 rtl/deserializer_out.sv | 138 +++++++++++++
 tb/tb_deserializer_out.sv | 290 +++++++++++++++++++++++++++++
 5 files changed

// File: rtl/serdes_pkg.sv
// rtl/serdes_pkg.sv - shared serial-link constants, word type and receive states
package serdes_pkg;

   localparam logic [7:0] COMMA   = 8'h3C;
   localparam logic [7:0] TRAILER = 8'hFC;

   typedef struct packed {
      logic       k;
      logic [7:0] data;
   } word_t;

   typedef enum logic [2:0] {
      ST_HUNT,
      ST_CONFIRM,
      ST_LOCKED,
      ST_BYTE1,
      ST_BYTE2,
      ST_TRAILER
   } rx_state_t;

endpackage

// File: rtl/deserializer_out_if.sv
// rtl/deserializer_out_if.sv - serial input and payload/status outputs of the receiver
interface deserializer_out_if;

   logic        serial_i;
   logic [23:0] data_o;
   logic        valid_o;
   logic        err_o;
   logic        lock_o;

   modport master (output serial_i, input data_o, valid_o, err_o, lock_o);
   modport slave  (input serial_i, output data_o, valid_o, err_o, lock_o);

endinterface

// File: rtl/rx_word_align.sv
// rtl/rx_word_align.sv - bit shifter, 9-bit word framing and comma search
module rx_word_align
   import serdes_pkg::*;
#(
   parameter logic [8:0] ALIGN_WORD = {1'b1, COMMA}
) (
   input  logic  clk_i,
   input  logic  rst_ni,
   input  logic  serial_i,
   input  logic  hunt,
   output word_t wrd,
   output logic  wrd_stb,
   output logic  aligned
);

   logic [8:0] sh;
   logic [3:0] bit_cnt;

   // Bit-level search only while hunting; once aligned the counter alone frames words.
   assign aligned = hunt && (sh == ALIGN_WORD);
   assign wrd_stb = (bit_cnt == 4'd8);
   assign wrd     = word_t'(sh);

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         sh      <= '0;
         bit_cnt <= '0;
      end else begin
         sh <= {serial_i, sh[8:1]};
         if (aligned || wrd_stb) begin
            bit_cnt <= '0;
         end else begin
            bit_cnt <= bit_cnt + 4'd1;
         end
      end
   end

endmodule

// File: rtl/deserializer_out.sv
// rtl/deserializer_out.sv - receive framer: comma lock, frame parsing, payload output
module deserializer_out
   import serdes_pkg::*;
#(
   parameter int unsigned LOCK_CNT = 2,
   parameter logic [7:0]  COMMA    = serdes_pkg::COMMA,
   parameter logic [7:0]  TRAILER  = serdes_pkg::TRAILER
) (
   input logic               clk_i,
   input logic               rst_ni,
   deserializer_out_if.slave bus
);

   localparam word_t      K_COMMA   = '{k: 1'b1, data: COMMA};
   localparam word_t      D_TRAILER = '{k: 1'b0, data: TRAILER};
   localparam logic [2:0] LOCK_TGT  = 3'(LOCK_CNT);

   rx_state_t  state;
   logic [2:0] comma_cnt;
   logic [7:0] d0, d1, d2;
   word_t      wrd;
   logic       wrd_stb;
   logic       aligned;
   logic       hunt;

   assign hunt = (state == ST_HUNT);

   rx_word_align #(.ALIGN_WORD(K_COMMA)) u_align (
      .clk_i    (clk_i),
      .rst_ni   (rst_ni),
      .serial_i (bus.serial_i),
      .hunt     (hunt),
      .wrd      (wrd),
      .wrd_stb  (wrd_stb),
      .aligned  (aligned)
   );

   always_ff @(posedge clk_i or negedge rst_ni) begin
      if (!rst_ni) begin
         state       <= ST_HUNT;
         comma_cnt   <= '0;
         d0          <= '0;
         d1          <= '0;
         d2          <= '0;
         bus.data_o  <= '0;
         bus.valid_o <= 1'b0;
         bus.err_o   <= 1'b0;
         bus.lock_o  <= 1'b0;
      end else begin
         bus.valid_o <= 1'b0;
         bus.err_o   <= 1'b0;
         case (state)
            ST_HUNT: begin
               if (aligned) begin
                  comma_cnt <= 3'd1;
                  if (LOCK_CNT == 1) begin
                     state      <= ST_LOCKED;
                     bus.lock_o <= 1'b1;
                  end else begin
                     state <= ST_CONFIRM;
                  end
               end
            end
            ST_CONFIRM: begin
               if (wrd_stb) begin
                  if (wrd == K_COMMA) begin
                     comma_cnt <= comma_cnt + 3'd1;
                     if (comma_cnt + 3'd1 == LOCK_TGT) begin
                        state      <= ST_LOCKED;
                        bus.lock_o <= 1'b1;
                     end
                  end else begin
                     state     <= ST_HUNT;
                     comma_cnt <= '0;
                  end
               end
            end
            ST_LOCKED: begin
               if (wrd_stb && wrd != K_COMMA) begin
                  if (!wrd.k) begin
                     d0    <= wrd.data;
                     state <= ST_BYTE1;
                  end else begin
                     bus.err_o  <= 1'b1;
                     bus.lock_o <= 1'b0;
                     comma_cnt  <= '0;
                     state      <= ST_HUNT;
                  end
               end
            end
            ST_BYTE1, ST_BYTE2: begin
               if (wrd_stb) begin
                  if (!wrd.k) begin
                     if (state == ST_BYTE1) begin
                        d1    <= wrd.data;
                        state <= ST_BYTE2;
                     end else begin
                        d2    <= wrd.data;
                        state <= ST_TRAILER;
                     end
                  end else if (wrd == K_COMMA) begin
                     // A comma mid-frame re-syncs: drop the partial frame but keep lock.
                     bus.err_o <= 1'b1;
                     state     <= ST_LOCKED;
                  end else begin
                     bus.err_o  <= 1'b1;
                     bus.lock_o <= 1'b0;
                     comma_cnt  <= '0;
                     state      <= ST_HUNT;
                  end
               end
            end
            ST_TRAILER: begin
               if (wrd_stb) begin
                  if (wrd == D_TRAILER) begin
                     bus.data_o  <= {d2, d1, d0};
                     bus.valid_o <= 1'b1;
                     state       <= ST_LOCKED;
                  end else if (wrd.k && wrd != K_COMMA) begin
                     bus.err_o  <= 1'b1;
                     bus.lock_o <= 1'b0;
                     comma_cnt  <= '0;
                     state      <= ST_HUNT;
                  end else begin
                     bus.err_o <= 1'b1;
                     state     <= ST_LOCKED;
                  end
               end
            end
            default: begin
               state      <= ST_HUNT;
               bus.lock_o <= 1'b0;
            end
         endcase
      end
   end

endmodule

// File: tb/tb_deserializer_out.sv
// tb/tb_deserializer_out.sv - randomized bench with a word-level reference model
module tb_deserializer_out;
   import serdes_pkg::*;

   localparam int         LOCK_CNT = 2;
   localparam logic [8:0] KC = {1'b1, COMMA};
   localparam logic [8:0] TR = {1'b0, TRAILER};

   typedef struct packed {
      logic [31:0] at;
      logic        v;
      logic        e;
      logic        l;
      logic [23:0] d;
   } ev_t;

   logic        clk = 1'b0;
   logic        rst_n = 1'b0;
   int unsigned cyc = 0;
   int          checks = 0;
   int          errors = 0;
   int          pulse_viol = 0;

   ev_t exp_q[$];
   ev_t obs_q[$];

   // word-level reference state
   logic        m_locked = 1'b0;
   int          m_commas = 0;
   int          m_pos = 0;
   logic [7:0]  m_bytes[3];
   logic [23:0] m_data = '0;

   deserializer_out_if bus();

   deserializer_out #(.LOCK_CNT(LOCK_CNT)) dut (
      .clk_i  (clk),
      .rst_ni (rst_n),
      .bus    (bus)
   );

   always #5 clk = ~clk;
   always @(posedge clk) cyc <= cyc + 1;

   logic prev_lock = 1'b0;
   logic prev_pulse = 1'b0;
   always @(negedge clk) begin
      if (!rst_n) begin
         prev_lock  = 1'b0;
         prev_pulse = 1'b0;
      end else begin
         if (bus.valid_o || bus.err_o || bus.lock_o !== prev_lock)
            obs_q.push_back('{cyc, bus.valid_o, bus.err_o, bus.lock_o, bus.data_o});
         if ((bus.valid_o && bus.err_o) || ((bus.valid_o || bus.err_o) && prev_pulse))
            pulse_viol++;
         prev_lock  = bus.lock_o;
         prev_pulse = bus.valid_o || bus.err_o;
      end
   end

   task automatic model_reset();
      m_locked = 1'b0;
      m_commas = 0;
      m_pos    = 0;
      m_data   = '0;
      exp_q.delete();
      obs_q.delete();
   endtask

   task automatic model_word(input logic [8:0] w, input int unsigned c);
      logic v, e, old_lock, lose;
      v = 1'b0; e = 1'b0; lose = 1'b0;
      old_lock = m_locked;
      if (!m_locked) begin
         if (w == KC) begin
            m_commas++;
            if (m_commas >= LOCK_CNT) m_locked = 1'b1;
         end else begin
            m_commas = 0;
         end
      end else if (m_pos == 0) begin
         if (w != KC) begin
            if (!w[8]) begin m_bytes[0] = w[7:0]; m_pos = 1; end
            else begin e = 1'b1; lose = 1'b1; end
         end
      end else if (m_pos < 3) begin
         if (!w[8]) begin m_bytes[m_pos] = w[7:0]; m_pos++; end
         else if (w == KC) begin e = 1'b1; m_pos = 0; end
         else begin e = 1'b1; lose = 1'b1; end
      end else begin
         if (w == TR) begin
            v = 1'b1;
            m_data = {m_bytes[2], m_bytes[1], m_bytes[0]};
         end else begin
            e = 1'b1;
            if (w[8] && w != KC) lose = 1'b1;
         end
         m_pos = 0;
      end
      if (lose) begin m_locked = 1'b0; m_commas = 0; m_pos = 0; end
      if (v || e || m_locked != old_lock) exp_q.push_back('{c + 2, v, e, m_locked, m_data});
   endtask

   task automatic send_bit(input logic b);
      @(posedge clk);
      #1 bus.serial_i = b;
   endtask

   task automatic send_word(input logic [8:0] w);
      for (int i = 0; i < 9; i++) send_bit(w[i]);
      model_word(w, cyc);
   endtask

   task automatic idle(input int n);
      repeat (n) send_word(KC);
   endtask

   task automatic send_frame(input logic [23:0] d);
      send_word(KC);
      send_word({1'b0, d[7:0]});
      send_word({1'b0, d[15:8]});
      send_word({1'b0, d[23:16]});
      send_word(TR);
   endtask

   task automatic test_reset();
      bus.serial_i = 1'b0;
      rst_n = 1'b0;
      repeat (3) @(posedge clk);
      #1;
      checks++; if (bus.data_o !== 24'h0) begin errors++; $display("FAIL reset_data: got %h, expected 000000", bus.data_o); end
      checks++; if (bus.valid_o !== 1'b0) begin errors++; $display("FAIL reset_valid: got %b, expected 0", bus.valid_o); end
      checks++; if (bus.err_o !== 1'b0) begin errors++; $display("FAIL reset_err: got %b, expected 0", bus.err_o); end
      checks++; if (bus.lock_o !== 1'b0) begin errors++; $display("FAIL reset_lock: got %b, expected 0", bus.lock_o); end
      rst_n = 1'b1;
      model_reset();
   endtask

   task automatic test_lock();
      repeat ($urandom_range(0, 7)) send_bit(1'b0);
      idle(LOCK_CNT + 2);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL lock_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL lock_ev%0d: got at=%0d v=%b e=%b l=%b d=%h, expected at=%0d v=%b e=%b l=%b d=%h", i, obs_q[i].at, obs_q[i].v, obs_q[i].e, obs_q[i].l, obs_q[i].d, exp_q[i].at, exp_q[i].v, exp_q[i].e, exp_q[i].l, exp_q[i].d); end
      end
      checks++; if (bus.lock_o !== 1'b1) begin errors++; $display("FAIL lock_level: got %b, expected 1", bus.lock_o); end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_frame();
      send_frame(24'hA1B2C3);
      idle($urandom_range(0, 1));
      send_frame(24'h3C3C3C);
      for (int n = 0; n < 4; n++) begin
         idle($urandom_range(0, 2));
         send_frame(24'($urandom));
      end
      idle(3);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL frame_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL frame_ev%0d: got at=%0d v=%b e=%b l=%b d=%h, expected at=%0d v=%b e=%b l=%b d=%h", i, obs_q[i].at, obs_q[i].v, obs_q[i].e, obs_q[i].l, obs_q[i].d, exp_q[i].at, exp_q[i].v, exp_q[i].e, exp_q[i].l, exp_q[i].d); end
      end
      checks++;
      if (obs_q.size() == 0 || obs_q[0].d !== 24'hA1B2C3 || obs_q[0].v !== 1'b1) begin
         errors++; $display("FAIL frame_first: got %0d events / d=%h, expected valid d=a1b2c3", obs_q.size(), (obs_q.size() != 0) ? obs_q[0].d : 24'h0);
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_back_to_back();
      send_frame(24'h000001);
      send_frame(24'hFFFFFF);
      idle(3);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL b2b_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL b2b_ev%0d: got at=%0d v=%b e=%b l=%b d=%h, expected at=%0d v=%b e=%b l=%b d=%h", i, obs_q[i].at, obs_q[i].v, obs_q[i].e, obs_q[i].l, obs_q[i].d, exp_q[i].at, exp_q[i].v, exp_q[i].e, exp_q[i].l, exp_q[i].d); end
      end
      checks++;
      if (obs_q.size() < 2) begin
         errors++; $display("FAIL b2b_period: got %0d pulses, expected 2", obs_q.size());
      end else if (obs_q[1].at - obs_q[0].at != 32'd45) begin
         errors++; $display("FAIL b2b_period: got %0d cycles, expected 45", obs_q[1].at - obs_q[0].at);
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_bad_trailer();
      send_word(KC);
      send_word({1'b0, 8'($urandom)});
      send_word({1'b0, 8'($urandom)});
      send_word({1'b0, 8'($urandom)});
      send_word({1'b0, 8'hFD});
      send_frame(24'($urandom));
      idle(3);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL trailer_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL trailer_ev%0d: got at=%0d v=%b e=%b l=%b d=%h, expected at=%0d v=%b e=%b l=%b d=%h", i, obs_q[i].at, obs_q[i].v, obs_q[i].e, obs_q[i].l, obs_q[i].d, exp_q[i].at, exp_q[i].v, exp_q[i].e, exp_q[i].l, exp_q[i].d); end
      end
      checks++; if (bus.lock_o !== 1'b1) begin errors++; $display("FAIL trailer_lock: got %b, expected 1", bus.lock_o); end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_comma_in_frame();
      send_word(KC);
      send_word({1'b0, 8'($urandom)});
      send_word({1'b0, 8'($urandom)});
      send_word(KC);
      send_frame(24'h123456);
      idle(3);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL resync_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL resync_ev%0d: got at=%0d v=%b e=%b l=%b d=%h, expected at=%0d v=%b e=%b l=%b d=%h", i, obs_q[i].at, obs_q[i].v, obs_q[i].e, obs_q[i].l, obs_q[i].d, exp_q[i].at, exp_q[i].v, exp_q[i].e, exp_q[i].l, exp_q[i].d); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_kcode_error();
      idle(1);
      send_word(9'h1BC);
      idle(LOCK_CNT + 1);
      send_frame(24'($urandom));
      idle(3);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL kcode_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL kcode_ev%0d: got at=%0d v=%b e=%b l=%b d=%h, expected at=%0d v=%b e=%b l=%b d=%h", i, obs_q[i].at, obs_q[i].v, obs_q[i].e, obs_q[i].l, obs_q[i].d, exp_q[i].at, exp_q[i].v, exp_q[i].e, exp_q[i].l, exp_q[i].d); end
      end
      checks++; if (bus.lock_o !== 1'b1) begin errors++; $display("FAIL kcode_relock: got %b, expected 1", bus.lock_o); end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_mid_reset();
      logic [8:0] d1w;
      d1w = {1'b0, 8'($urandom)};
      send_word(KC);
      send_word({1'b0, 8'($urandom)});
      for (int i = 0; i < 4; i++) send_bit(d1w[i]);
      @(posedge clk);
      #2 rst_n = 1'b0;
      bus.serial_i = 1'b0;
      #1;
      checks++; if (bus.lock_o !== 1'b0) begin errors++; $display("FAIL midrst_lock: got %b, expected 0", bus.lock_o); end
      checks++; if (bus.data_o !== 24'h0) begin errors++; $display("FAIL midrst_data: got %h, expected 000000", bus.data_o); end
      checks++; if (bus.valid_o !== 1'b0 || bus.err_o !== 1'b0) begin errors++; $display("FAIL midrst_pulse: got v=%b e=%b, expected 0 0", bus.valid_o, bus.err_o); end
      model_reset();
      repeat (3) @(posedge clk);
      #1 rst_n = 1'b1;
      repeat ($urandom_range(0, 7)) send_bit(1'b0);
      idle(LOCK_CNT + 1);
      send_frame(24'($urandom));
      idle(3);
      checks++; if (obs_q.size() != exp_q.size()) begin errors++; $display("FAIL midrst_count: got %0d events, expected %0d", obs_q.size(), exp_q.size()); end
      for (int i = 0; i < exp_q.size() && i < obs_q.size(); i++) begin
         checks++;
         if (obs_q[i] !== exp_q[i]) begin errors++; $display("FAIL midrst_ev%0d: got at=%0d v=%b e=%b l=%b d=%h, expected at=%0d v=%b e=%b l=%b d=%h", i, obs_q[i].at, obs_q[i].v, obs_q[i].e, obs_q[i].l, obs_q[i].d, exp_q[i].at, exp_q[i].v, exp_q[i].e, exp_q[i].l, exp_q[i].d); end
      end
      obs_q.delete(); exp_q.delete();
   endtask

   task automatic test_pulse_rules();
      checks++;
      if (pulse_viol != 0) begin errors++; $display("FAIL pulse_rules: got %0d overlapping/consecutive pulses, expected 0", pulse_viol); end
   endtask

   initial begin
      test_reset();
      test_lock();
      test_frame();
      test_back_to_back();
      test_bad_trailer();
      test_comma_in_frame();
      test_kcode_error();
      test_mid_reset();
      test_pulse_rules();
      $display("Simulation finished: %0d checks, %0d errors", checks, errors);
      $finish;
   end

   initial begin
      #2000000;
      $display("FAIL watchdog: simulation did not reach its summary");
      $fatal(1, "timeout");
   end

endmodule
